// File: rtl/cpu_mux_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mux_pkg
// Shared types and constants for the operand selector datapath.
//   DATA_W        datapath word width
//   MAX_SEL_W     widest channel index the payload can carry
//   sel_width()   index width for an N-way select (never below 1 bit)
//   payload_t     word + forwarded index + illegal flag, as held in the skid
//   skid_state_e  occupancy of the two-entry skid buffer
// ---------------------------------------------------------------------------
package cpu_mux_pkg;

    localparam int DATA_W    = 19;
    localparam int MAX_SEL_W = 8;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic                 illegal;
        logic [MAX_SEL_W-1:0] idx;
        logic [DATA_W-1:0]    data;
    } payload_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// pipe_skid_buf
// Two-entry valid/ready register slice: an output register (O) backed by a
// skid register (S). in_ready comes straight from a flop, so there is no
// combinational path from out_ready to in_ready; the skid entry absorbs the
// word that arrives in the cycle downstream stalls.
//   clk, rst_n           clock, async active-low reset
//   in_data/valid/ready  upstream handshake
//   out_data/valid/ready downstream handshake
// ---------------------------------------------------------------------------
module pipe_skid_buf
    import cpu_mux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    skid_state_e      state_q;
    logic [WIDTH-1:0] o_q;
    logic [WIDTH-1:0] s_q;
    logic             rdy_q;
    logic             accept;

    // rdy_q is high exactly when S is empty (EMPTY or ONE).
    assign accept = in_valid && rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SKID_EMPTY;
            o_q     <= '0;
            s_q     <= '0;
            rdy_q   <= 1'b1;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (accept) begin
                        o_q     <= in_data;
                        state_q <= SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && out_ready) begin
                        o_q <= in_data;
                    end else if (accept) begin
                        // O is stalled: park the new word in S and stop accepting
                        s_q     <= in_data;
                        state_q <= SKID_FULL;
                        rdy_q   <= 1'b0;
                    end else if (out_ready) begin
                        state_q <= SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (out_ready) begin
                        o_q     <= s_q;
                        state_q <= SKID_ONE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= SKID_EMPTY;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != SKID_EMPTY);
    assign out_data  = o_q;

endmodule

// File: rtl/operand_mux_pipe.sv
// ---------------------------------------------------------------------------
// operand_mux_pipe
// N-way operand selector with a registered, back-pressure-safe output.
// Selects one of NUM_IN packed channels by in_sel; an out-of-range select
// forwards DEFAULT_IDX, is flagged on out_illegal and is recorded in a sticky
// flag and a saturating counter at accept time.
//   clk, rst_n                          clock, async active-low reset
//   in_data/in_sel/in_valid/in_ready    upstream handshake (channel k at
//                                       in_data[k*WIDTH +: WIDTH])
//   out_data/out_idx/out_illegal        forwarded word, index, illegal flag
//   out_valid/out_ready                 downstream handshake
//   err_clr                             clear sel_err / err_cnt
//   sel_err, err_cnt                    sticky illegal flag, saturating count
// ---------------------------------------------------------------------------
module operand_mux_pipe
    import cpu_mux_pkg::*;
#(
    parameter  int WIDTH       = DATA_W,
    parameter  int NUM_IN      = 4,
    parameter  int DEFAULT_IDX = 0,
    parameter  int ERR_CNT_W   = 8,
    localparam int SEL_W       = sel_width(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_idx,
    output logic                    out_illegal,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    sel_err,
    output logic [ERR_CNT_W-1:0]    err_cnt
);

    logic [WIDTH-1:0]     chan [NUM_IN];
    logic                 sel_legal;
    logic [SEL_W-1:0]     fwd_idx;
    logic [WIDTH-1:0]     sel_word;
    logic                 accept;
    payload_t             pl_in;
    payload_t             pl_out;
    logic                 sel_err_q, sel_err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    for (genvar k = 0; k < NUM_IN; k++) begin : g_chan
        assign chan[k] = in_data[k*WIDTH +: WIDTH];
    end

    // Extra bit so the compare is meaningful when NUM_IN is a power of two.
    assign sel_legal = ({1'b0, in_sel} < (SEL_W+1)'(NUM_IN));
    assign fwd_idx   = sel_legal ? in_sel : SEL_W'(DEFAULT_IDX);

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (fwd_idx == SEL_W'(k)) sel_word = chan[k];
        end
    end

    // The payload carries a DATA_W-wide word; WIDTH is expected to match it.
    always_comb begin
        pl_in         = '0;
        pl_in.data    = DATA_W'(sel_word);
        pl_in.idx     = MAX_SEL_W'(fwd_idx);
        pl_in.illegal = !sel_legal;
    end

    pipe_skid_buf #(
        .WIDTH ($bits(payload_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (pl_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (pl_out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign out_data    = WIDTH'(pl_out.data);
    assign out_idx     = SEL_W'(pl_out.idx);
    assign out_illegal = pl_out.illegal;

    assign accept = in_valid && in_ready;

    // An illegal accept beats a simultaneous clear: the count restarts at 1.
    always_comb begin
        sel_err_d = sel_err_q;
        err_cnt_d = err_cnt_q;
        if (accept && !sel_legal) begin
            sel_err_d = 1'b1;
            if (err_clr)
                err_cnt_d = ERR_CNT_W'(1);
            else if (err_cnt_q != '1)
                err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        end else if (err_clr) begin
            sel_err_d = 1'b0;
            err_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            sel_err_q <= sel_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign sel_err = sel_err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: doc/operand_mux_pipe.md
Name: operand_mux_pipe

Overview:
- Parametrised N-way operand selector for the 19-bit datapath. Successor to the fixed 3:1 combinational operand mux.
- Registers the selected word behind a valid/ready handshake with a skid stage, so ALU/writeback back-pressure never drops an operand.
- Flags and counts out-of-range selects instead of silently defaulting.

Parameters:
- WIDTH, 19, data word width.
- NUM_IN, 4, number of input channels (>=2).
- SEL_W, $clog2(NUM_IN), select width (derived, not overridden).
- DEFAULT_IDX, 0, channel forwarded on an illegal select.
- ERR_CNT_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_data  in  NUM_IN*WIDTH  packed channels; channel k = bits [k*WIDTH +: WIDTH].
- in_sel  in  SEL_W  channel index, sampled with in_data.
- in_valid  in  1  upstream offers data+sel.
- in_ready  out  1  block can accept this cycle.
- out_data  out  WIDTH  selected word.
- out_idx  out  SEL_W  index actually forwarded (DEFAULT_IDX if illegal).
- out_illegal  out  1  forwarded word came from an illegal select.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- err_clr  in  1  synchronous clear of sticky error state.
- sel_err  out  1  sticky: an illegal select has been accepted since reset/clear.
- err_cnt  out  ERR_CNT_W  saturating count of accepted illegal selects.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_idx=0, out_illegal=0, skid empty, in_ready=1, sel_err=0, err_cnt=0.
- Accept: in_valid && in_ready. Transfer: out_valid && out_ready.
- Legal select: in_sel < NUM_IN. Illegal select: in_sel >= NUM_IN, possible only when NUM_IN is not a power of 2.
- On accept, the word selected by in_sel (or DEFAULT_IDX if illegal) is captured together with the index and the illegal bit.
- Latency 1 cycle: accept at edge N gives out_valid at N+1 when the output register is empty or transferring.
- Storage is two entries: output register (O) and skid register (S).
- in_ready = !S_valid, driven from a register, with no combinational path from out_ready.
- States are EMPTY (O empty), ONE (O full, S empty) and FULL (O and S full).
  - EMPTY: accept -> ONE.
  - ONE: accept with no transfer -> FULL (data goes to S). Accept with transfer -> ONE (O reloads). Transfer with no accept -> EMPTY.
  - FULL: transfer -> ONE, S moves to O. No accept is possible.
- Ordering is strict FIFO. No entry is dropped or duplicated. out_data, out_idx and out_illegal stay stable while out_valid && !out_ready.
- Throughput is 1 word/cycle with out_ready held high.
- Error tracking happens at accept time, not transfer time.
  - Illegal accept: sel_err <= 1 and err_cnt <= err_cnt+1, saturating at 2^ERR_CNT_W-1.
  - err_clr alone: sel_err <= 0 and err_cnt <= 0.
  - err_clr in the same cycle as an illegal accept: the accept wins, so sel_err=1 and err_cnt=1.
- A select of X/invalid on a cycle with no accept has no effect.
- Reset mid-operation clears both entries immediately. Any in-flight words are discarded.

Decomposition:
- Shared package cpu_mux_pkg:
  - DATA_W=19 constant.
  - sel_width function (clog2, minimum 1).
  - payload struct type {data, idx, illegal} used by the skid stage.
- One sub-module: pipe_skid_buf (WIDTH-generic 2-entry valid/ready skid buffer, clk/rst_n). The mux, illegal detection and error counter stay in operand_mux_pipe.

Test Plan:
- NUM_IN=4, ch0..3=0x00011/0x00022/0x00033/0x7FFFF, sel=3, out_ready=1 -> next cycle out_data=0x7FFFF, out_idx=3, out_illegal=0, sel_err=0.
- NUM_IN=3, DEFAULT_IDX=0, ch0=0x12345, sel=3 -> out_data=0x12345, out_idx=0, out_illegal=1, sel_err=1, err_cnt=1.
- Back-pressure: out_ready=0, accept A=0x00001 then B=0x00002 -> in_ready=0 after B. out_ready=1 -> A then B on consecutive cycles; a third offer C is not accepted until in_ready rises.
- Streaming 16 words with out_ready=1 -> 16 transfers in 16 consecutive cycles starting 1 cycle after the first accept, order preserved.
- ERR_CNT_W=2, 5 illegal accepts -> err_cnt=3 (saturated). err_clr together with a 6th illegal accept -> err_cnt=1, sel_err=1.
- Assert rst_n low while state is FULL, mid-cycle -> out_valid=0, in_ready=1, err_cnt=0 immediately, without waiting for a clock edge.
